// File: rtl/apb_master_bridge.sv
// APB3 master bridge: turns the level-sensitive command interface into
// SETUP/ACCESS bus cycles toward two slaves selected by the address MSB.
// Optional macro APB_TIMEOUT_EN adds a wait-state watchdog that
// force-completes a stalled ACCESS with an error after TIMEOUT_CYCLES waits.
module apb_master_bridge #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              transfer,
  input  logic              READ_WRITE,
  input  logic [ADDR_W-1:0] apb_write_paddr,
  input  logic [DATA_W-1:0] apb_write_data,
  input  logic [ADDR_W-1:0] apb_read_paddr,
  output logic [DATA_W-1:0] apb_read_data_out,
  output logic              psel1,
  output logic              psel2,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              xfer_done,
  output logic              xfer_err,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              psel1_q, psel1_d, psel2_q, psel2_d;
  logic              penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d, err_q, err_d;
  logic              capture;
  logic              timeout;
  logic [ADDR_W-1:0] cmd_addr;

  // Address of the command presented this cycle (only used when captured)
  assign cmd_addr = READ_WRITE ? apb_read_paddr : apb_write_paddr;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wcnt_q, wcnt_d;

  // Wait-state counter: cleared in SETUP, counts ACCESS cycles without pready
  always_comb begin
    wcnt_d = wcnt_q;
    if (state_q == S_SETUP)
      wcnt_d = '0;
    else if (state_q == S_ACCESS && !pready)
      wcnt_d = wcnt_q + 1'b1;
  end

  // The last allowed wait cycle completes the transfer with an error
  assign timeout = (state_q == S_ACCESS) && !pready &&
                   (wcnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Wait counter register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) wcnt_q <= '0;
    else          wcnt_q <= wcnt_d;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Next-state and registered-output computation for the bus FSM
  always_comb begin
    state_d   = state_q;
    psel1_d   = psel1_q;
    psel2_d   = psel2_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (transfer) begin
          capture = 1'b1;
        end else begin
          psel1_d   = 1'b0;
          psel2_d   = 1'b0;
          penable_d = 1'b0;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (pready || timeout) begin
          done_d = 1'b1;
          err_d  = timeout | pslverr;
          // Only a clean read completion updates the read-data register
          if (pready && !pslverr && !pwrite_q)
            rdata_d = prdata;
          if (transfer) begin
            capture = 1'b1;
          end else begin
            state_d   = S_IDLE;
            psel1_d   = 1'b0;
            psel2_d   = 1'b0;
            penable_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
      end
    endcase
    // Command capture shared by IDLE and back-to-back ACCESS completion
    if (capture) begin
      state_d   = S_SETUP;
      pwrite_d  = ~READ_WRITE;
      paddr_d   = cmd_addr;
      if (!READ_WRITE)
        pwdata_d = apb_write_data;
      psel1_d   = ~cmd_addr[ADDR_W-1];
      psel2_d   = cmd_addr[ADDR_W-1];
      penable_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel1_q   <= psel1_d;
      psel2_q   <= psel2_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign psel1             = psel1_q;
  assign psel2             = psel2_q;
  assign penable           = penable_q;
  assign pwrite            = pwrite_q;
  assign paddr             = paddr_q;
  assign pwdata            = pwdata_q;
  assign apb_read_data_out = rdata_q;
  assign xfer_done         = done_q;
  assign xfer_err          = err_q;
  assign busy              = (state_q != S_IDLE);

endmodule
